// File: rtl/mult_div_if.sv
// Issue/result bundle between decode control and the multiply/divide unit.
// The issuer drives the request and MTHI/MTLO strobes; the unit returns status and HI/LO.
interface mult_div_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      mdOp;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            hiWrite;
  logic            loWrite;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, mdOp, opA, opB, hiWrite, loWrite, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, mdOp, opA, opB, hiWrite, loWrite, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operates on magnitudes for XLEN cycles, then applies the sign fix in one extra cycle.
module mult_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic        clk,
  input logic        reset,
  mult_div_if.slave  bus
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  logic            dz_q, dz_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            is_signed;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [AW-1:0]   mul_step, div_step;
  logic [AW-1:0]   prod_fix;
  logic [XLEN-1:0] quo, rem;

  // Datapath for one iteration: acc holds {partial/remainder, multiplier/quotient}
  always_comb begin
    is_signed = ~bus.mdOp[0];
    abs_a     = (is_signed && bus.opA[XLEN-1]) ? XLEN'(-bus.opA) : bus.opA;
    abs_b     = (is_signed && bus.opB[XLEN-1]) ? XLEN'(-bus.opB) : bus.opB;

    mul_sum   = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};

    div_shift = acc_q[AW-1:XLEN-1];
    div_diff  = div_shift - {1'b0, mcand_q};
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

    prod_fix  = (sign_a_q ^ sign_b_q) ? AW'(-acc_q) : acc_q;
    quo       = acc_q[XLEN-1:0];
    rem       = acc_q[AW-1:XLEN];
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          op_d     = bus.mdOp;
          sign_a_d = is_signed & bus.opA[XLEN-1];
          sign_b_d = is_signed & bus.opB[XLEN-1];
          dz_d     = (bus.opB == '0);
          if (bus.mdOp[1]) begin
            acc_d   = {{XLEN{1'b0}}, abs_a};
            mcand_d = abs_b;
          end else begin
            acc_d   = {{XLEN{1'b0}}, abs_b};
            mcand_d = abs_a;
          end
        end else begin
          if (bus.hiWrite) hi_d = bus.wdata;
          if (bus.loWrite) lo_d = bus.wdata;
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_step : mul_step;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          // A zero divisor leaves the dividend magnitude in rem, so the sign fix restores opA
          lo_d = dz_q ? '1 : ((sign_a_q ^ sign_b_q) ? XLEN'(-quo) : quo);
          hi_d = sign_a_q ? XLEN'(-rem) : rem;
        end else begin
          hi_d = prod_fix[AW-1:XLEN];
          lo_d = prod_fix[XLEN-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO go into a queue at issue,
// and a negedge monitor pops and checks them on every done pulse.
module tb_mult_div_unit;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   done_seen;
  exp_t exp_q[$];

  mult_div_if #(.XLEN(XLEN)) bus ();

  mult_div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Result monitor; decoupled from stimulus
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      exp_t e;
      done_seen++;
      check("busy_low_with_done", 32'(bus.busy), 32'd0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got done=1, required no pending op");
      end else begin
        e = exp_q.pop_front();
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
      end
    end
  end

  task automatic idle_inputs();
    bus.start   = 1'b0;
    bus.mdOp    = 2'd0;
    bus.opA     = '0;
    bus.opB     = '0;
    bus.hiWrite = 1'b0;
    bus.loWrite = 1'b0;
    bus.wdata   = '0;
  endtask

  // Wait (bounded) for done; returns cycles busy was seen high
  task automatic wait_done(output int busy_cycles);
    bit got;
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.done === 1'b1) got = 1'b1;
      else begin
        if (bus.busy === 1'b1) busy_cycles++;
        @(negedge clk);
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: got no done in 100 cycles, required a done pulse");
    end
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] eh, input logic [XLEN-1:0] el);
    int bc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdOp  = op;
    bus.opA   = a;
    bus.opB   = b;
    exp_q.push_back('{hi: eh, lo: el});
    @(negedge clk);
    idle_inputs();
    wait_done(bc);
    check("busy_cycles", 32'(bc), 32'd33);
  endtask

  initial begin
    int bc;
    int done_before;
    total = 0;
    bad = 0;
    done_seen = 0;
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset_hi",   bus.hi, 32'h0);
    check("reset_lo",   bus.lo, 32'h0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(2'd3, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op(2'd3, 32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);

    // Start and MTHI during RUN must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdOp  = 2'd1;
    bus.opA   = 32'h0001_0000;
    bus.opB   = 32'h0001_0000;
    exp_q.push_back('{hi: 32'h0000_0001, lo: 32'h0000_0000});
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    bus.start   = 1'b1;
    bus.mdOp    = 2'd3;
    bus.opA     = 32'd50;
    bus.opB     = 32'd5;
    bus.hiWrite = 1'b1;
    bus.wdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    wait_done(bc);
    check("busy_cycles_ignored_start", 32'(bc), 32'd22);
    repeat (40) @(negedge clk);
    check("no_second_op_hi", bus.hi, 32'h0000_0001);

    // MTHI / MTLO in IDLE
    done_before = done_seen;
    bus.hiWrite = 1'b1;
    bus.wdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    idle_inputs();
    check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
    check("mthi_lo_kept", bus.lo, 32'h0000_0000);
    bus.hiWrite = 1'b1;
    bus.loWrite = 1'b1;
    bus.wdata   = 32'hCAFE_F00D;
    @(negedge clk);
    idle_inputs();
    check("mthilo_hi", bus.hi, 32'hCAFE_F00D);
    check("mthilo_lo", bus.lo, 32'hCAFE_F00D);
    // Start wins over MTLO in the same IDLE cycle
    bus.start   = 1'b1;
    bus.mdOp    = 2'd3;
    bus.opA     = 32'd9;
    bus.opB     = 32'd4;
    bus.loWrite = 1'b1;
    bus.wdata   = 32'h1111_1111;
    exp_q.push_back('{hi: 32'd1, lo: 32'd2});
    @(negedge clk);
    idle_inputs();
    check("mtlo_blocked_by_start", bus.lo, 32'hCAFE_F00D);
    wait_done(bc);
    check("no_done_for_mthi", 32'(done_seen - done_before), 32'd1);

    // Reset in the middle of RUN discards the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.mdOp  = 2'd1;
    bus.opA   = 32'd3;
    bus.opB   = 32'd5;
    @(negedge clk);
    idle_inputs();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 32'(bus.busy), 32'd0);
    check("midreset_hi", bus.hi, 32'h0);
    check("midreset_lo", bus.lo, 32'h0);
    done_before = done_seen;
    repeat (50) @(negedge clk);
    check("midreset_no_done", 32'(done_seen - done_before), 32'd0);

    run_op(2'd1, 32'd6, 32'd7, 32'd0, 32'd42);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide unit with architectural HI/LO registers, executing MULT, MULTU, DIV and DIVU beside the combinational ALU in the MIPS datapath. The decode/control stage issues an operation with a start/busy handshake and stalls MFHI/MFLO until busy drops. HI/LO are also written directly by MTHI/MTLO. One operation runs at a time; there is no pipelining inside the unit.

Parameters:
XLEN, 32, operand width; iteration count equals XLEN; hi/lo are XLEN bits each.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  issue request; sampled only in IDLE.
mdOp  in  2  operation: 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU; sampled with start.
opA  in  XLEN  rs value: multiplicand or dividend; sampled with start.
opB  in  XLEN  rt value: multiplier or divisor; sampled with start.
hiWrite  in  1  MTHI strobe.
loWrite  in  1  MTLO strobe.
wdata  in  XLEN  MTHI/MTLO data.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle pulse; the result is valid in hi/lo.
hi  out  XLEN  HI register.
lo  out  XLEN  LO register.

Behaviour:
- Reset (synchronous, sampled on a clk edge while reset = 1) has highest priority:
  - state goes to IDLE and the counter clears;
  - hi = 0, lo = 0, busy = 0, done = 0;
  - an in-flight operation is discarded; reset mid-operation leaves no partial result.
- States:
  - IDLE: start = 1 goes to RUN; otherwise stays in IDLE.
  - RUN: exactly XLEN cycles, counter 0..XLEN-1; at counter = XLEN-1 goes to FIX.
  - FIX: one cycle, then IDLE.
- Accepting start in IDLE:
  - latch mdOp;
  - latch |opA| and |opB| for signed ops; raw opA and opB for unsigned ops;
  - latch sign bits and divide-by-zero flag (opB = 0).
- busy is registered: 1 in RUN and FIX, 0 in IDLE.
- Latency, with start sampled at edge E0:
  - RUN spans E0..EXLEN;
  - FIX spans EXLEN..EXLEN+1;
  - hi/lo are written at edge EXLEN+1 (E33 for XLEN = 32);
  - done = 1 for the single cycle after EXLEN+1, with busy = 0 in that same cycle.
- start while busy is ignored: no queueing and no effect on the running op. Issue is blocked by the stall logic.
- Multiply:
  - shift-add, one multiplier bit per RUN cycle, producing a 2*XLEN-bit magnitude product;
  - in FIX, MULT with differing signs negates the product (two's complement, 2*XLEN bits);
  - hi = upper XLEN bits, lo = lower XLEN bits.
- Divide:
  - restoring division, one quotient bit per RUN cycle on magnitudes;
  - in FIX, DIV negates the quotient if the signs differ and negates the remainder if the dividend is negative (remainder takes the sign of the dividend);
  - lo = quotient, hi = remainder;
  - DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0, with no special handling.
- Divide by zero (signed or unsigned):
  - the full latency is still taken;
  - lo = all ones; hi = original opA as sampled, no sign fix;
  - no trap or flag.
- MTHI/MTLO:
  - in IDLE with start = 0: hiWrite loads hi <= wdata and loWrite loads lo <= wdata on that edge; both may be asserted together;
  - when start = 1 in the same IDLE cycle, hiWrite and loWrite are ignored;
  - in RUN or FIX they are ignored.
- hi/lo hold their value at all times other than the result write, MTHI/MTLO and reset.
- done is never asserted without a completed operation. done is never asserted for MTHI/MTLO.

Test Plan:
1. Reset, then MULTU opA = 0xFFFFFFFF, opB = 0xFFFFFFFF -> busy high for 33 cycles; done pulses once; hi = 0xFFFFFFFE, lo = 0x00000001.
2. MULT opA = 0xFFFFFFFD (-3), opB = 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB (-21).
3. DIV opA = 0xFFFFFFF9 (-7), opB = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). DIVU 100 / 7 -> lo = 14, hi = 2.
4. DIVU 0x12345678 / 0 -> lo = 0xFFFFFFFF, hi = 0x12345678 after the full latency. DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
5. Start a MULTU, then pulse start (DIVU) and hiWrite (wdata = 0xDEADBEEF) at RUN cycle 10 -> both ignored; hi/lo show the MULTU result. In IDLE, hiWrite with 0xDEADBEEF -> hi = 0xDEADBEEF, done stays low.
6. Assert reset at RUN cycle 20 -> next cycle busy = 0, hi = lo = 0, done never pulses. A following start completes normally.
